// File: rtl/key_phase_scheduler_if.sv
// key_phase_scheduler_if: load/clear controls and key presentation outputs of
// the key phase scheduler, grouped so the scheduler and its driver share one bundle.
// The slave modport is the scheduler's view. The master modport is the view of
// whatever drives the key stream.
interface key_phase_scheduler_if #(
  parameter int KEY_W     = 7,
  parameter int NUM_KEYS  = 2,
  parameter int PHASE_LEN = 7
);
  localparam int PERIOD = NUM_KEYS * PHASE_LEN;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic             i_loadStart;
  logic             i_sdi;
  logic             i_sdiValid;
  logic             i_clearKeys;
  logic [KEY_W-1:0] o_keyOut;
  logic [SW-1:0]    o_keyIdx;
  logic [CW-1:0]    o_cntOut;
  logic             o_armed;
  logic             o_busy;
  logic             o_loadDone;
  logic             o_loadErr;

  modport slave (
    input  i_loadStart, i_sdi, i_sdiValid, i_clearKeys,
    output o_keyOut, o_keyIdx, o_cntOut, o_armed, o_busy, o_loadDone, o_loadErr
  );

  modport master (
    output i_loadStart, i_sdi, i_sdiValid, i_clearKeys,
    input  o_keyOut, o_keyIdx, o_cntOut, o_armed, o_busy, o_loadDone, o_loadErr
  );
endinterface

// File: rtl/key_phase_scheduler.sv
// key_phase_scheduler: holds NUM_KEYS key words for a time-keyed locked FSM.
// Words are loaded bit-serially into a shadow bank, then copied into the active bank
// only at the phase-counter wrap, so a reload never tears a period.
// Optional macro KEY_PARITY_EN adds a trailing even-parity bit to the stream.
// A bad parity bit pulses o_loadErr and drops the load.
module key_phase_scheduler #(
  parameter int KEY_W     = 7,
  parameter int NUM_KEYS  = 2,
  parameter int PHASE_LEN = 7
) (
  input  logic                   i_clk,
  input  logic                   i_rstN,
  key_phase_scheduler_if.slave   bus
);
  localparam int PERIOD  = NUM_KEYS * PHASE_LEN;
  localparam int CW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int KEYBITS = NUM_KEYS * KEY_W;
`ifdef KEY_PARITY_EN
  localparam int STREAMBITS = KEYBITS + 1;
`else
  localparam int STREAMBITS = KEYBITS;
`endif
  localparam int BW = (STREAMBITS > 1) ? $clog2(STREAMBITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PENDING} stateT;

  stateT              r_state;
  stateT              w_nextState;
  logic [CW-1:0]      r_cnt;
  logic [BW-1:0]      r_bitCnt;
  logic [BW-1:0]      w_nextBitCnt;
  logic [KEYBITS-1:0] r_shadow;
  logic [KEY_W-1:0]   r_active [NUM_KEYS];
  logic               r_armed;
  logic               r_loadDone;
  logic               w_cntWrap;
  logic               w_shiftEn;
  logic               w_lastBit;
  logic               w_commit;
  logic [SW-1:0]      w_keyIdx;
`ifdef KEY_PARITY_EN
  logic               r_loadErr;
  logic               w_parityErr;
`endif

  assign w_cntWrap = (r_cnt == CW'(PERIOD - 1));
  assign w_keyIdx  = SW'(r_cnt / CW'(PHASE_LEN));

  assign bus.o_cntOut   = r_cnt;
  assign bus.o_keyIdx   = w_keyIdx;
  assign bus.o_keyOut   = r_armed ? r_active[w_keyIdx] : '0;
  assign bus.o_armed    = r_armed;
  assign bus.o_busy     = (r_state != IDLE);
  assign bus.o_loadDone = r_loadDone;
`ifdef KEY_PARITY_EN
  assign bus.o_loadErr  = r_loadErr;
`else
  assign bus.o_loadErr  = 1'b0;
`endif

  // Free-running phase counter; resets to the last phase so the first edge lands on 0.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_cnt <= CW'(PERIOD - 1);
    end else if (w_cntWrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Load FSM state register.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Load FSM next state: serial capture, end-of-stream detection and wrap-aligned commit.
  always_comb begin
    w_nextState  = r_state;
    w_nextBitCnt = r_bitCnt;
    w_shiftEn    = 1'b0;
    w_lastBit    = 1'b0;
    w_commit     = 1'b0;
`ifdef KEY_PARITY_EN
    w_parityErr  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.i_loadStart) begin
          w_nextState  = SHIFT;
          w_nextBitCnt = '0;
        end
      end
      SHIFT: begin
        if (bus.i_loadStart) begin
          w_nextBitCnt = '0;
        end else if (bus.i_sdiValid) begin
          w_shiftEn    = (r_bitCnt < BW'(KEYBITS));
          w_nextBitCnt = r_bitCnt + 1'b1;
          if (r_bitCnt == BW'(STREAMBITS - 1)) begin
            w_lastBit    = 1'b1;
            w_nextBitCnt = '0;
            w_nextState  = PENDING;
`ifdef KEY_PARITY_EN
            if (bus.i_sdi != ^r_shadow) begin
              w_parityErr = 1'b1;
              w_nextState = IDLE;
            end
`endif
          end
        end
      end
      PENDING: begin
        if (w_cntWrap) begin
          w_nextState = IDLE;
          w_commit    = !bus.i_clearKeys;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Key banks and load status: shadow fills bit by bit; active changes only on commit or clear.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_bitCnt   <= '0;
      r_shadow   <= '0;
      r_armed    <= 1'b0;
      r_loadDone <= 1'b0;
      for (int s = 0; s < NUM_KEYS; s++) begin
        r_active[s] <= '0;
      end
    end else begin
      r_bitCnt   <= w_nextBitCnt;
      r_loadDone <= w_lastBit;
      if (w_shiftEn) begin
        r_shadow[r_bitCnt] <= bus.i_sdi;
      end
      if (bus.i_clearKeys) begin
        r_armed <= 1'b0;
        for (int s = 0; s < NUM_KEYS; s++) begin
          r_active[s] <= '0;
        end
      end else if (w_commit) begin
        r_armed <= 1'b1;
        for (int s = 0; s < NUM_KEYS; s++) begin
          r_active[s] <= r_shadow[s*KEY_W +: KEY_W];
        end
      end
    end
  end

`ifdef KEY_PARITY_EN
  // Parity error pulse, registered alongside the load-done pulse.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_loadErr <= 1'b0;
    end else begin
      r_loadErr <= w_parityErr;
    end
  end
`endif

endmodule

// File: tb/tb_key_phase_scheduler.sv
// tb_key_phase_scheduler: scoreboard bench for key_phase_scheduler.
// Every driven cycle runs a reference model and queues the expected outputs.
// The queue is popped and compared one time unit after the rising edge.
// Honors KEY_PARITY_EN like the design.
module tb_key_phase_scheduler;
  localparam int KEY_W      = 7;
  localparam int NUM_KEYS   = 2;
  localparam int PHASE_LEN  = 7;
  localparam int PERIOD     = NUM_KEYS * PHASE_LEN;
  localparam int KEYBITS    = NUM_KEYS * KEY_W;
`ifdef KEY_PARITY_EN
  localparam int STREAMBITS = KEYBITS + 1;
`else
  localparam int STREAMBITS = KEYBITS;
`endif

  typedef struct {
    int cnt;
    int idx;
    int key;
    bit armed;
    bit busy;
    bit done;
    bit err;
  } expT;

  logic clk = 1'b0;
  logic rstN;
  expT  sbQ[$];
  int   checks   = 0;
  int   failures = 0;

  int                 mCnt;
  int                 mState;
  int                 mBitCnt;
  logic [KEYBITS-1:0] mShadow;
  logic [KEY_W-1:0]   mActive [NUM_KEYS];
  bit                 mArmed;

  key_phase_scheduler_if #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS), .PHASE_LEN(PHASE_LEN)) bus ();

  key_phase_scheduler #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS), .PHASE_LEN(PHASE_LEN)) dut (
    .i_clk  (clk),
    .i_rstN (rstN),
    .bus    (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    mCnt    = PERIOD - 1;
    mState  = 0;
    mBitCnt = 0;
    mShadow = '0;
    mArmed  = 1'b0;
    for (int s = 0; s < NUM_KEYS; s++) mActive[s] = '0;
  endtask

  // Reference behaviour for one rising edge; state 0=idle, 1=shift, 2=pending.
  task automatic modelStep(input bit ls, input bit d, input bit v, input bit clr, output expT e);
    int nCnt;
    bit commit;
    commit = 1'b0;
    e.done = 1'b0;
    e.err  = 1'b0;
    nCnt = (mCnt == PERIOD - 1) ? 0 : mCnt + 1;
    case (mState)
      0: if (ls) begin mState = 1; mBitCnt = 0; end
      1: begin
        if (ls) begin
          mBitCnt = 0;
        end else if (v) begin
          if (mBitCnt < KEYBITS) mShadow[mBitCnt] = d;
          if (mBitCnt == STREAMBITS - 1) begin
            e.done  = 1'b1;
            mState  = 2;
            mBitCnt = 0;
`ifdef KEY_PARITY_EN
            if (d != ^mShadow) begin
              e.err  = 1'b1;
              mState = 0;
            end
`endif
          end else begin
            mBitCnt++;
          end
        end
      end
      default: if (mCnt == PERIOD - 1) begin mState = 0; commit = !clr; end
    endcase
    if (commit) begin
      for (int s = 0; s < NUM_KEYS; s++) mActive[s] = mShadow[s*KEY_W +: KEY_W];
      mArmed = 1'b1;
    end
    if (clr) begin
      for (int s = 0; s < NUM_KEYS; s++) mActive[s] = '0;
      mArmed = 1'b0;
    end
    mCnt    = nCnt;
    e.cnt   = mCnt;
    e.idx   = mCnt / PHASE_LEN;
    e.key   = mArmed ? int'(mActive[e.idx]) : 0;
    e.armed = mArmed;
    e.busy  = (mState != 0);
  endtask

  task automatic applyStimulus(input bit ls, input bit d, input bit v, input bit clr);
    expT e;
    expT got;
    bus.i_loadStart = ls;
    bus.i_sdi       = d;
    bus.i_sdiValid  = v;
    bus.i_clearKeys = clr;
    modelStep(ls, d, v, clr, e);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput("sbDepth", sbQ.size(), 1);
    got = sbQ.pop_front();
    checkOutput("cnt", 32'(bus.o_cntOut), got.cnt);
    checkOutput("keyIdx", 32'(bus.o_keyIdx), got.idx);
    checkOutput("keyOut", 32'(bus.o_keyOut), got.key);
    checkOutput("armed", 32'(bus.o_armed), 32'(got.armed));
    checkOutput("busy", 32'(bus.o_busy), 32'(got.busy));
    checkOutput("loadDone", 32'(bus.o_loadDone), 32'(got.done));
    checkOutput("loadErr", 32'(bus.o_loadErr), 32'(got.err));
    bus.i_loadStart = 1'b0;
    bus.i_sdi       = 1'b0;
    bus.i_sdiValid  = 1'b0;
    bus.i_clearKeys = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
  endtask

  task automatic waitCnt(input int target);
    for (int i = 0; i < PERIOD && mCnt != target; i++) idle(1);
    checkOutput("waitCnt", 32'(bus.o_cntOut), target);
  endtask

  task automatic waitCommit();
    for (int i = 0; i < 2 * PERIOD && mState != 0; i++) idle(1);
    checkOutput("commitCnt", 32'(bus.o_cntOut), 0);
    checkOutput("commitArmed", 32'(bus.o_armed), 1);
  endtask

  task automatic loadKeys(input logic [KEY_W-1:0] k0, input logic [KEY_W-1:0] k1, input bit gaps);
    logic [KEYBITS-1:0] stream;
    stream = {k1, k0};
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < KEYBITS; i++) begin
      if (gaps) applyStimulus(0, 1, 0, 0);
      applyStimulus(0, stream[i], 1, 0);
    end
`ifdef KEY_PARITY_EN
    applyStimulus(0, ^stream, 1, 0);
`endif
    checkOutput("loadDonePulse", 32'(bus.o_loadDone), 1);
  endtask

  task automatic checkBank(input string tag, input logic [KEY_W-1:0] k0, input logic [KEY_W-1:0] k1);
    waitCnt(0);
    checkOutput({tag, "Slot0"}, 32'(bus.o_keyOut), 32'(k0));
    idle(PHASE_LEN);
    checkOutput({tag, "Slot1"}, 32'(bus.o_keyOut), 32'(k1));
    checkOutput({tag, "Idx1"}, 32'(bus.o_keyIdx), 1);
  endtask

  initial begin
    logic [KEYBITS-1:0] stream;
    rstN = 1'b0;
    bus.i_loadStart = 1'b0;
    bus.i_sdi       = 1'b0;
    bus.i_sdiValid  = 1'b0;
    bus.i_clearKeys = 1'b0;
    resetModel();
    #12;
    checkOutput("rstCnt", 32'(bus.o_cntOut), PERIOD - 1);
    checkOutput("rstKey", 32'(bus.o_keyOut), 0);
    checkOutput("rstArmed", 32'(bus.o_armed), 0);
    checkOutput("rstBusy", 32'(bus.o_busy), 0);
    checkOutput("rstDone", 32'(bus.o_loadDone), 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    $display("[TB] free-running counter, no keys");
    idle(PERIOD + 1);
    checkOutput("unarmedKey", 32'(bus.o_keyOut), 0);

    $display("[TB] contiguous load 0x21/0x68");
    loadKeys(7'h21, 7'h68, 1'b0);
    checkOutput("pendingBusy", 32'(bus.o_busy), 1);
    waitCommit();
    checkBank("load1", 7'h21, 7'h68);

    $display("[TB] reload 0x7F/0x00 starting at cnt 3");
    waitCnt(3);
    loadKeys(7'h7F, 7'h00, 1'b0);
    checkOutput("holdOldKey", 32'(bus.o_keyOut), 32'h21);
    waitCommit();
    checkBank("reload", 7'h7F, 7'h00);

    $display("[TB] gapped load 0x21/0x68");
    loadKeys(7'h21, 7'h68, 1'b1);
    waitCommit();
    checkBank("gapped", 7'h21, 7'h68);

    $display("[TB] clear at cnt 9");
    waitCnt(9);
    applyStimulus(0, 0, 0, 1);
    checkOutput("clrCnt", 32'(bus.o_cntOut), 10);
    checkOutput("clrKey", 32'(bus.o_keyOut), 0);
    checkOutput("clrArmed", 32'(bus.o_armed), 0);
    idle(2);

    $display("[TB] restart mid-load, clear during shift");
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    stream = {7'h2A, 7'h55};
    for (int i = 0; i < KEYBITS; i++) applyStimulus(0, stream[i], 1, i == 3);
`ifdef KEY_PARITY_EN
    applyStimulus(0, ^stream, 1, 0);
`endif
    checkOutput("restartDone", 32'(bus.o_loadDone), 1);
    waitCommit();
    checkBank("restart", 7'h55, 7'h2A);

`ifdef KEY_PARITY_EN
    $display("[TB] bad parity load");
    stream = {7'h68, 7'h21};
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < KEYBITS; i++) applyStimulus(0, stream[i], 1, 0);
    applyStimulus(0, ~(^stream), 1, 0);
    checkOutput("parityErr", 32'(bus.o_loadErr), 1);
    checkOutput("parityBusy", 32'(bus.o_busy), 0);
    checkOutput("parityArmed", 32'(bus.o_armed), 1);
    idle(PERIOD);
    checkBank("parityKept", 7'h55, 7'h2A);
`endif

    $display("[TB] clear coincident with commit");
    loadKeys(7'h11, 7'h22, 1'b0);
    waitCnt(PERIOD - 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("clrCommitArmed", 32'(bus.o_armed), 0);
    checkOutput("clrCommitBusy", 32'(bus.o_busy), 0);
    checkOutput("clrCommitKey", 32'(bus.o_keyOut), 0);
    idle(PERIOD);
    checkOutput("clrCommitStays", 32'(bus.o_armed), 0);

    $display("[TB] asynchronous reset mid-load");
    loadKeys(7'h33, 7'h44, 1'b0);
    waitCommit();
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0);
    rstN = 1'b0;
    #1;
    checkOutput("midRstCnt", 32'(bus.o_cntOut), PERIOD - 1);
    checkOutput("midRstBusy", 32'(bus.o_busy), 0);
    checkOutput("midRstArmed", 32'(bus.o_armed), 0);
    checkOutput("midRstKey", 32'(bus.o_keyOut), 0);
    resetModel();
    #1;
    rstN = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
